// File: rtl/bip_sequencer_if.sv
// Host-side bus of the BIP sequencer: command handshake plus byte-wide report stream.
// master = host/sink side, slave = sequencer side.
interface bip_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    output cmd_valid, cmd, tx_ready,
    input  cmd_ready, tx_valid, tx_data
  );

  modport slave (
    input  cmd_valid, cmd, tx_ready,
    output cmd_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/bip_sequencer.sv
// Run/step/abort sequencer for a BIP CPU with a 4-byte status report after every stop.
// Optional run-limit watchdog enabled by defining SEQ_CYCLE_LIMIT_EN.
module bip_sequencer #(
  parameter int len_addr   = 11,
  parameter int len_opcode = 5,
  parameter int len_cnt    = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  bip_sequencer_if.slave        host,
  input  logic [len_opcode-1:0] Opcode,
  input  logic [len_addr-1:0]   pc,
  output logic                  cpu_ena,
  output logic                  cpu_clear,
  output logic                  halted,
  output logic                  timeout
);

  if (len_cnt < 9 || len_cnt > 16 || MAX_CYCLES < 0) begin : g_param_check
    $error("bip_sequencer: len_cnt must be 9..16 and MAX_CYCLES non-negative");
  end

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {IDLE, RUN, STEP, REPORT, HALT} state_t;

  state_t               state_reg, state_next;
  state_t               ret_reg, ret_next;
  logic [len_cnt-1:0]   cnt_reg, cnt_next, cnt_sat;
  logic [1:0]           idx_reg, idx_next;
  logic [len_addr-1:0]  pc_lat_reg, pc_lat_next;
  logic [15:0]          cnt_ext, pc_ext;
  logic [7:0]           report_byte;
  logic                 op_nz;
  logic                 cmd_run, cmd_step, cmd_abort;

`ifdef SEQ_CYCLE_LIMIT_EN
  localparam logic [len_cnt-1:0] cnt_limit = len_cnt'(MAX_CYCLES);
  logic timeout_reg, timeout_next;
  assign timeout = timeout_reg;
`else
  assign timeout = 1'b0;
`endif

  assign op_nz     = (Opcode != '0);
  assign cmd_run   = host.cmd_valid && (host.cmd == CMD_RUN);
  assign cmd_step  = host.cmd_valid && (host.cmd == CMD_STEP);
  assign cmd_abort = host.cmd_valid && (host.cmd == CMD_ABORT);
  assign cnt_sat   = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
  assign cnt_ext   = 16'(cnt_reg);
  assign pc_ext    = 16'(pc_lat_reg);
  assign halted    = (state_reg == HALT);

  always_comb begin
    case (idx_reg)
      2'd0:    report_byte = cnt_ext[15:8];
      2'd1:    report_byte = cnt_ext[7:0];
      2'd2:    report_byte = pc_ext[15:8];
      default: report_byte = pc_ext[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      ret_reg    <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= 2'd0;
      pc_lat_reg <= '0;
`ifdef SEQ_CYCLE_LIMIT_EN
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      pc_lat_reg <= pc_lat_next;
`ifdef SEQ_CYCLE_LIMIT_EN
      timeout_reg <= timeout_next;
`endif
    end
  end

  // pc is captured on the edge entering REPORT: the address of the last instruction considered.
  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    pc_lat_next    = pc_lat_reg;
`ifdef SEQ_CYCLE_LIMIT_EN
    timeout_next   = timeout_reg;
`endif
    cpu_ena        = 1'b0;
    cpu_clear      = 1'b0;
    host.cmd_ready = 1'b0;
    host.tx_valid  = 1'b0;
    host.tx_data   = 8'h00;
    case (state_reg)
      IDLE: begin
        host.cmd_ready = 1'b1;
        if (cmd_run)       state_next = RUN;
        else if (cmd_step) state_next = STEP;
      end
      RUN: begin
        host.cmd_ready = 1'b1;
        if (cmd_abort) begin
          state_next  = REPORT;
          ret_next    = IDLE;
          pc_lat_next = pc;
        end else if (!op_nz) begin
          state_next  = REPORT;
          ret_next    = HALT;
          pc_lat_next = pc;
`ifdef SEQ_CYCLE_LIMIT_EN
        end else if (cnt_reg == cnt_limit) begin
          state_next   = REPORT;
          ret_next     = HALT;
          pc_lat_next  = pc;
          timeout_next = 1'b1;
`endif
        end else begin
          cpu_ena  = 1'b1;
          cnt_next = cnt_sat;
        end
      end
      STEP: begin
        cpu_ena     = op_nz;
        cnt_next    = op_nz ? cnt_sat : cnt_reg;
        state_next  = REPORT;
        ret_next    = op_nz ? IDLE : HALT;
        pc_lat_next = pc;
      end
      REPORT: begin
        host.tx_valid = 1'b1;
        host.tx_data  = report_byte;
        if (host.tx_ready) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) state_next = ret_reg;
        end
      end
      HALT: begin
        host.cmd_ready = 1'b1;
        if (cmd_run) begin
          cpu_clear    = 1'b1;
          cnt_next     = '0;
`ifdef SEQ_CYCLE_LIMIT_EN
          timeout_next = 1'b0;
`endif
          state_next   = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
